// File: rtl/mem_addr_mux_pkg.sv
// Shared dual-rail codewords, output-state enum and rail-pair classification helpers
// for the memory address bit multiplexer.
package mem_addr_mux_pkg;

    localparam logic [1:0] DR_NULL    = 2'b00;
    localparam logic [1:0] DR_D0      = 2'b01;
    localparam logic [1:0] DR_D1      = 2'b10;
    localparam logic [1:0] DR_ILLEGAL = 2'b11;

    typedef enum logic {
        NULL_OUT = 1'b0,
        DATA_OUT = 1'b1
    } out_state_e;

    function automatic logic is_null(input logic [1:0] rails);
        return rails == DR_NULL;
    endfunction

    function automatic logic is_data(input logic [1:0] rails);
        return (rails == DR_D0) || (rails == DR_D1);
    endfunction

    function automatic logic is_illegal(input logic [1:0] rails);
        return rails == DR_ILLEGAL;
    endfunction

    function automatic logic [1:0] dr_encode(input logic bit_val);
        return bit_val ? DR_D1 : DR_D0;
    endfunction

endpackage

// File: rtl/mem_addr_mux_dr_complete.sv
// Wavefront classifier for the four dual-rail inputs: complete DATA, complete NULL,
// or any input carrying the illegal 11 codeword.
module dr_complete
    import mem_addr_mux_pkg::*;
(
    input  logic [1:0] ph0_i,
    input  logic [1:0] mi_i,
    input  logic [1:0] sa_i,
    input  logic [1:0] ia_i,
    output logic       all_data_o,
    output logic       all_null_o,
    output logic       any_illegal_o
);

    always_comb begin
        all_data_o    = is_data(ph0_i) && is_data(mi_i) && is_data(sa_i) && is_data(ia_i);
        all_null_o    = is_null(ph0_i) && is_null(mi_i) && is_null(sa_i) && is_null(ia_i);
        any_illegal_o = is_illegal(ph0_i) || is_illegal(mi_i)
                     || is_illegal(sa_i)  || is_illegal(ia_i);
    end

endmodule

// File: rtl/mem_addr_mux.sv
// Dual-rail address bit select: Ad = (!PH0 && Mi) ? SA : IA, registered with
// DATA/NULL hysteresis and a one-cycle-late illegal-codeword flag.
module mem_addr_mux
    import mem_addr_mux_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic PH0_t,
    input  logic PH0_f,
    input  logic Mi_t,
    input  logic Mi_f,
    input  logic SA_t,
    input  logic SA_f,
    input  logic IA_t,
    input  logic IA_f,
    output logic Ad_t,
    output logic Ad_f,
    output logic ko,
    output logic err
);

    logic [1:0] ph0_rails;
    logic [1:0] mi_rails;
    logic [1:0] sa_rails;
    logic [1:0] ia_rails;

    logic       all_data;
    logic       all_null;
    logic       any_illegal;
    logic       sel_bit;

    out_state_e state_q;
    logic [1:0] ad_q;
    logic       err_q;

    assign ph0_rails = {PH0_t, PH0_f};
    assign mi_rails  = {Mi_t, Mi_f};
    assign sa_rails  = {SA_t, SA_f};
    assign ia_rails  = {IA_t, IA_f};

    dr_complete u_complete (
        .ph0_i         (ph0_rails),
        .mi_i          (mi_rails),
        .sa_i          (sa_rails),
        .ia_i          (ia_rails),
        .all_data_o    (all_data),
        .all_null_o    (all_null),
        .any_illegal_o (any_illegal)
    );

    // Only meaningful when all_data is set; the true rail carries the bit value.
    always_comb begin
        sel_bit = (!PH0_t && Mi_t) ? SA_t : IA_t;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= NULL_OUT;
            ad_q    <= DR_NULL;
            err_q   <= 1'b0;
        end else begin
            err_q <= any_illegal;
            // An illegal codeword freezes the state; otherwise only complete wavefronts move it.
            if (!any_illegal) begin
                case (state_q)
                    NULL_OUT: begin
                        if (all_data) begin
                            state_q <= DATA_OUT;
                            ad_q    <= dr_encode(sel_bit);
                        end
                    end
                    DATA_OUT: begin
                        if (all_null) begin
                            state_q <= NULL_OUT;
                            ad_q    <= DR_NULL;
                        end
                    end
                    default: begin
                        state_q <= NULL_OUT;
                        ad_q    <= DR_NULL;
                    end
                endcase
            end
        end
    end

    assign Ad_t = ad_q[1];
    assign Ad_f = ad_q[0];
    assign ko   = ~(ad_q[1] | ad_q[0]);
    assign err  = err_q;

endmodule

// File: tb/tb_mem_addr_mux.sv
// Randomized and directed checks of mem_addr_mux against a wavefront-level reference model.
module tb_mem_addr_mux;

    logic clk = 1'b0;
    logic rst;
    logic PH0_t, PH0_f, Mi_t, Mi_f, SA_t, SA_f, IA_t, IA_f;
    logic Ad_t, Ad_f, ko, err;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model: output codeword and expected err flag.
    logic [1:0] m_ad  = 2'b00;
    logic       m_err = 1'b0;

    always #5 clk = ~clk;

    mem_addr_mux dut (
        .clk   (clk),
        .rst   (rst),
        .PH0_t (PH0_t),
        .PH0_f (PH0_f),
        .Mi_t  (Mi_t),
        .Mi_f  (Mi_f),
        .SA_t  (SA_t),
        .SA_f  (SA_f),
        .IA_t  (IA_t),
        .IA_f  (IA_f),
        .Ad_t  (Ad_t),
        .Ad_f  (Ad_f),
        .ko    (ko),
        .err   (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [1:0] ph0, input logic [1:0] mi,
                         input logic [1:0] sa, input logic [1:0] ia);
        {PH0_t, PH0_f} = ph0;
        {Mi_t, Mi_f}   = mi;
        {SA_t, SA_f}   = sa;
        {IA_t, IA_f}   = ia;
    endtask

    function automatic logic [1:0] enc(input int b);
        return (b != 0) ? 2'b10 : 2'b01;
    endfunction

    task automatic model_edge();
        logic [1:0] c [4];
        int n_data = 0;
        int n_null = 0;
        bit ill = 0;
        int ph0, mi, sa, ia, res;
        c[0] = {PH0_t, PH0_f};
        c[1] = {Mi_t, Mi_f};
        c[2] = {SA_t, SA_f};
        c[3] = {IA_t, IA_f};
        foreach (c[k]) begin
            if (c[k] == 2'b00) n_null++;
            else if (c[k] == 2'b11) ill = 1;
            else n_data++;
        end
        m_err = ill;
        if (!ill) begin
            if (m_ad == 2'b00 && n_data == 4) begin
                ph0 = (c[0] == 2'b10) ? 1 : 0;
                mi  = (c[1] == 2'b10) ? 1 : 0;
                sa  = (c[2] == 2'b10) ? 1 : 0;
                ia  = (c[3] == 2'b10) ? 1 : 0;
                res = (ph0 == 0 && mi == 1) ? sa : ia;
                m_ad = enc(res);
            end else if (m_ad != 2'b00 && n_null == 4) begin
                m_ad = 2'b00;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".ad"},  {30'd0, Ad_t, Ad_f}, {30'd0, m_ad});
        check({tag, ".ko"},  {31'd0, ko},  {31'd0, ~(m_ad[1] | m_ad[0])});
        check({tag, ".err"}, {31'd0, err}, {31'd0, m_err});
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        check_outputs(tag);
    endtask

    initial begin
        logic [1:0] codes [4];
        int mode;
        int b3, b2, b1, b0, want;

        rst = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 2'b00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_outputs("reset");
        check("reset.ko_const", {31'd0, ko}, 32'd1);

        step("idle_null");

        drive(2'b01, 2'b01, 2'b01, 2'b01);
        step("all_zero_data");
        check("all_zero.Ad_f", {31'd0, Ad_f}, 32'd1);
        drive(2'b00, 2'b00, 2'b00, 2'b00);
        step("all_zero_null");

        for (int i = 0; i < 16; i++) begin
            b3 = (i >> 3) & 1;
            b2 = (i >> 2) & 1;
            b1 = (i >> 1) & 1;
            b0 = i & 1;
            drive(enc(b3), enc(b2), enc(b1), enc(b0));
            step($sformatf("sweep%0d", i));
            want = (b3 == 0 && b2 == 1) ? b1 : b0;
            check($sformatf("sweep%0d.sel", i), {30'd0, Ad_t, Ad_f}, {30'd0, enc(want)});
            if (i == 6)  check("spot0110.Ad_t", {31'd0, Ad_t}, 32'd1);
            if (i == 14) check("spot1110.Ad_f", {31'd0, Ad_f}, 32'd1);
            if (i == 3)  check("spot0011.Ad_t", {31'd0, Ad_t}, 32'd1);
            drive(2'b00, 2'b00, 2'b00, 2'b00);
            step($sformatf("sweep%0d_null", i));
        end

        drive(2'b01, 2'b10, 2'b10, 2'b00);
        step("partial_ia_null");
        check("partial.held_null", {30'd0, Ad_t, Ad_f}, 32'd0);
        drive(2'b01, 2'b10, 2'b10, 2'b10);
        step("partial_complete");
        check("partial.sa_sel", {30'd0, Ad_t, Ad_f}, 32'd2);
        drive(2'b00, 2'b10, 2'b10, 2'b10);
        step("partial_ph0_null");
        check("partial.held_data", {30'd0, Ad_t, Ad_f}, 32'd2);
        drive(2'b00, 2'b00, 2'b00, 2'b00);
        step("partial_all_null");

        drive(2'b01, 2'b01, 2'b11, 2'b10);
        step("illegal_sa");
        check("illegal.err", {31'd0, err}, 32'd1);
        check("illegal.ad_held", {30'd0, Ad_t, Ad_f}, 32'd0);
        drive(2'b01, 2'b01, 2'b01, 2'b10);
        step("illegal_cleared");
        check("cleared.err", {31'd0, err}, 32'd0);

        // Ad is now 10; reset must clear it without a clock edge.
        rst = 1'b1;
        #1;
        m_ad  = 2'b00;
        m_err = 1'b0;
        check("async_rst.ad", {30'd0, Ad_t, Ad_f}, 32'd0);
        check("async_rst.ko", {31'd0, ko}, 32'd1);
        drive(2'b00, 2'b00, 2'b00, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        step("post_reset");

        for (int n = 0; n < 400; n++) begin
            mode = $urandom_range(0, 3);
            for (int k = 0; k < 4; k++) begin
                case (mode)
                    0: codes[k] = 2'b00;
                    1: codes[k] = enc($urandom_range(0, 1));
                    default: begin
                        int r;
                        r = $urandom_range(0, 15);
                        if (r < 1)      codes[k] = 2'b11;
                        else if (r < 6) codes[k] = 2'b00;
                        else            codes[k] = enc($urandom_range(0, 1));
                    end
                endcase
            end
            drive(codes[0], codes[1], codes[2], codes[3]);
            step($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
